dbus_initiator: RTL and testbench

- Data-bus initiator (master) that drives peripheral responders: the GPIO/special-GPIO blocks and any other slave using type_dbus2peri_s / type_peri2dbus_s.
- Accepts single read/write commands on a valid/ready command port.
- Drives one dbus transaction, waits for the responder's one-cycle ack, then returns read data and status on a valid/ready response port.
- Used by the debug/boot loader path to reach peripherals without the core.

---
 rtl/dbus_initiator.sv | 159 +++++++++++++++
 tb/tb_dbus_initiator.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_initiator.sv
// dbus_initiator: single-outstanding data-bus master for peripheral responders.
//
// Takes one read/write command on a valid/ready port, drives a dbus request until the
// responder acks (or, optionally, a timeout expires), then holds the result on a
// valid/ready response port until it is consumed.
//
// Ports:
//   clk, rst         clock (posedge) and synchronous active-high reset
//   cmd_*            command port: valid/ready, we, addr, wdata
//   rsp_*            response port: valid/ready, rdata (0 for writes/errors), err
//   busy_o           high whenever not idle
//   periph_sel_o     peripheral select, identical to dbus req
//   dbus2peri_o      packed {addr[ADDR_W-1:0], w_data[DATA_W-1:0], w_en, req}
//   peri2dbus_i      packed {ack, r_data[DATA_W-1:0]}
//
// Optional feature macro: DBUS_INIT_TIMEOUT_EN
//   Defined:   abort REQ after TIMEOUT_CYCLES cycles without ack, reporting rsp_err_o=1.
//   Undefined: REQ waits indefinitely; rsp_err_o is tied 0.
module dbus_initiator #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic                     cmd_we_i,
    input  logic [ADDR_W-1:0]        cmd_addr_i,
    input  logic [DATA_W-1:0]        cmd_wdata_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [DATA_W-1:0]        rsp_rdata_o,
    output logic                     rsp_err_o,
    output logic                     busy_o,
    output logic                     periph_sel_o,
    output logic [ADDR_W+DATA_W+1:0] dbus2peri_o,
    input  logic [DATA_W:0]          peri2dbus_i
);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ack;
    logic [DATA_W-1:0]   r_data;
    logic                timeout;
    logic                req;

    assign ack    = peri2dbus_i[DATA_W];
    assign r_data = peri2dbus_i[DATA_W-1:0];

`ifdef DBUS_INIT_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == StIdle && cmd_valid_i) begin
            cnt_d = '0;
        end else if (state_q == StReq) begin
            if (ack) begin
                err_d = 1'b0;  // ack beats a simultaneous timeout
            end else begin
                cnt_d = cnt_q + CntW'(1);
                if (timeout) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign rsp_err_o = err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout            = 1'b0;
    assign rsp_err_o          = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    addr_d  = cmd_addr_i;
                    wdata_d = cmd_wdata_i;
                    we_d    = cmd_we_i;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (ack) begin
                    rdata_d = we_q ? '0 : r_data;
                    state_d = StResp;
                end else if (timeout) begin
                    rdata_d = '0;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

    // req comes straight from the state register, so it drops the cycle after ack is
    // sampled and the responder sees exactly one access per command.
    assign req          = (state_q == StReq);
    assign cmd_ready_o  = (state_q == StIdle);
    assign rsp_valid_o  = (state_q == StResp);
    assign busy_o       = (state_q != StIdle);
    assign periph_sel_o = req;
    assign rsp_rdata_o  = rdata_q;
    assign dbus2peri_o  = {addr_q, wdata_q, req & we_q, req};

endmodule

// File: tb/tb_dbus_initiator.sv
// Randomized self-checking bench for dbus_initiator with a behavioural responder and a
// per-command expectation model (request length, response data, error, access count).
module tb_dbus_initiator;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;
`ifdef DBUS_INIT_TIMEOUT_EN
    localparam bit ToEn = 1'b1;
`else
    localparam bit ToEn = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0]  cmd_addr;
    logic [DW-1:0]  cmd_wdata;
    logic           rsp_valid, rsp_ready;
    logic [DW-1:0]  rsp_rdata;
    logic           rsp_err, busy, periph_sel;
    logic [AW+DW+1:0] d2p;
    logic [DW:0]    p2d;

    always #5 clk = ~clk;

    dbus_initiator #(
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_addr_i  (cmd_addr),
        .cmd_wdata_i (cmd_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .busy_o      (busy),
        .periph_sel_o(periph_sel),
        .dbus2peri_o (d2p),
        .peri2dbus_i (p2d)
    );

    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_wen, d_req;
    assign d_addr  = d2p[AW+DW+1:DW+2];
    assign d_wdata = d2p[DW+1:2];
    assign d_wen   = d2p[1];
    assign d_req   = d2p[0];

    // Responder: acks during the ack_at-th consecutive cycle of req (0 = never acks).
    int            ack_at = 0;
    logic [DW-1:0] resp_data = '0;
    logic          stray_ack = 1'b0;
    logic [DW-1:0] stray_data = '0;
    int            req_cnt = 0;
    int            n_access = 0;
    logic          resp_ack;

    assign resp_ack = d_req && (ack_at != 0) && (req_cnt == ack_at - 1);
    assign p2d      = {resp_ack | stray_ack, stray_ack ? stray_data : resp_data};

    always @(posedge clk) begin
        req_cnt <= d_req ? req_cnt + 1 : 0;
        if (d_req && resp_ack) n_access <= n_access + 1;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Issue one command and follow it to its response. Starts and ends at a negedge.
    task automatic run_cmd(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [DW-1:0] rdata, input int ack, input int bp);
        bit            to;
        int            exp_req;
        logic [DW-1:0] exp_rd;
        int            nreq;
        int            acc0;
        to      = ToEn && (ack == 0 || ack > int'(TO));
        exp_req = to ? int'(TO) : ack;
        exp_rd  = (we || to) ? '0 : rdata;
        ack_at    = ack;
        resp_data = rdata;
        check_eq("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        acc0      = n_access;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        nreq = 0;
        while (d_req && nreq < 100) begin
            check_eq("req_addr", d_addr, addr);
            check_eq("req_wdata", d_wdata, wdata);
            check_eq("req_wen", d_wen, we);
            check_eq("sel_eq_req", periph_sel, 1);
            check_eq("cmd_ready_req", cmd_ready, 0);
            nreq++;
            @(negedge clk);
        end
        check_eq("req_cycles", nreq, exp_req);
        check_eq("accesses", n_access - acc0, to ? 0 : 1);
        check_eq("rsp_valid", rsp_valid, 1);
        check_eq("rsp_rdata", rsp_rdata, exp_rd);
        check_eq("rsp_err", rsp_err, to);
        for (int i = 0; i < bp; i++) begin
            // A stray ack during RESP must be ignored.
            stray_ack  = (i == 1);
            stray_data = $urandom;
            @(negedge clk);
            check_eq("bp_valid", rsp_valid, 1);
            check_eq("bp_rdata", rsp_rdata, exp_rd);
            check_eq("bp_err", rsp_err, to);
            check_eq("bp_cmd_ready", cmd_ready, 0);
        end
        stray_ack = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        ack_at    = 0;
        check_eq("post_cmd_ready", cmd_ready, 1);
        check_eq("post_rsp_valid", rsp_valid, 0);
        check_eq("post_busy", busy, 0);
        check_eq("post_req", d_req, 0);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_req", d_req, 0);
        check_eq("rst_wen", d_wen, 0);
        check_eq("rst_addr", d_addr, 0);
        check_eq("rst_wdata", d_wdata, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_rdata", rsp_rdata, 0);
        check_eq("rst_rsp_err", rsp_err, 0);
        check_eq("rst_busy", busy, 0);

        // rsp_ready and stray acks while idle do nothing.
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stray_ack  = 1'b1;
            stray_data = $urandom;
            @(negedge clk);
            check_eq("idle_rsp_valid", rsp_valid, 0);
            check_eq("idle_rdata", rsp_rdata, 0);
            check_eq("idle_cmd_ready", cmd_ready, 1);
            check_eq("idle_req", d_req, 0);
        end
        stray_ack = 1'b0;
        rsp_ready = 1'b0;

        run_cmd(1'b1, 32'h4, 32'h0000_A5A5, 32'h1234_5678, 2, 0);
        run_cmd(1'b0, 32'h0, 32'h0, 32'h0000_3C3C, 3, 5);
`ifdef DBUS_INIT_TIMEOUT_EN
        run_cmd(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 1);
        run_cmd(1'b0, 32'h14, 32'h0, 32'hCAFE_F00D, 8, 1);
`endif

        // Reset while in REQ drops req and discards the response.
        ack_at    = 0;
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = 32'h20;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("mid_req", d_req, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mrst_req", d_req, 0);
        check_eq("mrst_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            rsp_ready = 1'b1;
            @(negedge clk);
            check_eq("mrst_no_rsp", rsp_valid, 0);
        end
        rsp_ready = 1'b0;

        // Back-to-back pair after reset.
        run_cmd(1'b0, 32'h30, 32'h0, 32'h1111_2222, 1, 0);
        run_cmd(1'b0, 32'h34, 32'h0, 32'h3333_4444, 2, 0);

        for (int n = 0; n < 40; n++) begin
            int a;
            a = ToEn ? int'($urandom_range(0, TO + 2)) : int'($urandom_range(1, 6));
            run_cmd(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, a,
                    int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
